fp_mul_norm_round_pipe: RTL and testbench

//  Parametrised successor to the single-precision multiply normaliser. Takes the raw significand

---
 rtl/fp_mul_norm_round_pipe.sv | 130 +++++++++++++
 tb/tb_fp_mul_norm_round_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_norm_round_pipe.sv
// Two-stage multiply normalise/round/pack pipeline with valid/ready backpressure.
// Stage 1 normalises the raw significand product; stage 2 rounds, detects over/underflow and packs.
module fp_mul_norm_round_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2*(MAN_W+1)-1:0]     in_p,
    input  logic [EXP_W+1:0]           in_s,
    input  logic                       in_sign,
    input  logic [2:0]                 in_rm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXP_W+MAN_W:0]       out_result,
    output logic [2:0]                 out_flags
);
    localparam int PW = 2*(MAN_W+1);
    localparam int EW = EXP_W+2;
    localparam logic signed [EW:0] EMAX = (EW+1)'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    logic             s1_v, s2_v, s1_load, s2_load;
    logic [EW-1:0]    s1_e;
    logic [MAN_W-1:0] s1_m;
    logic             s1_g, s1_st, s1_sign, s1_zero;
    rm_e              s1_rm;

    assign s2_load   = s1_v && (!s2_v || out_ready);
    assign in_ready  = !s1_v || s2_load;
    assign s1_load   = in_valid && in_ready;
    assign out_valid = s2_v;

    logic [EW-1:0]    n_e;
    logic [MAN_W-1:0] n_m;
    logic             n_g, n_st;
    rm_e              n_rm;

    always_comb begin
        n_e  = in_s + {{(EW-1){1'b0}}, in_p[PW-1]};
        n_m  = in_p[PW-1] ? in_p[PW-2 -: MAN_W] : in_p[PW-3 -: MAN_W];
        n_g  = in_p[PW-1] ? in_p[PW-MAN_W-2]    : in_p[PW-MAN_W-3];
        n_st = in_p[PW-1] ? |in_p[PW-MAN_W-3:0] : |in_p[PW-MAN_W-4:0];
        n_rm = (in_rm > 3'd4) ? RM_RNE : rm_e'(in_rm);
    end

    logic                   inexact, inc, to_inf, ovf, unf;
    logic [MAN_W:0]         mr;
    logic signed [EW:0]     ef;
    logic [EXP_W+MAN_W:0]   n_res;
    logic [2:0]             n_flags;

    always_comb begin
        inexact = s1_g | s1_st;
        case (s1_rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = inexact & s1_sign;
            RM_RUP:  inc = inexact & ~s1_sign;
            RM_RMM:  inc = s1_g;
            default: inc = s1_g & (s1_st | s1_m[0]);
        endcase
        // Carry out of the mantissa leaves m at zero and bumps the exponent.
        mr  = {1'b0, s1_m} + {{MAN_W{1'b0}}, inc};
        ef  = $signed({s1_e[EW-1], s1_e}) + $signed({{EW{1'b0}}, mr[MAN_W]});
        ovf = (ef >= EMAX);
        unf = ef[EW] || (ef == '0);
        case (s1_rm)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = s1_sign;
            RM_RUP:  to_inf = ~s1_sign;
            default: to_inf = 1'b1;
        endcase
        n_res   = {s1_sign, ef[EXP_W-1:0], mr[MAN_W-1:0]};
        n_flags = {2'b00, inexact};
        if (s1_zero) begin
            n_res   = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
            n_flags = 3'b000;
        end else if (ovf) begin
            n_res   = to_inf ? {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                             : {s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            n_flags = 3'b101;
        end else if (unf) begin
            n_res   = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
            n_flags = 3'b011;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
            s1_e       <= '0;
            s1_m       <= '0;
            s1_g       <= 1'b0;
            s1_st      <= 1'b0;
            s1_sign    <= 1'b0;
            s1_zero    <= 1'b0;
            s1_rm      <= RM_RNE;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            if (s1_load)      s1_v <= 1'b1;
            else if (s2_load) s1_v <= 1'b0;
            if (s1_load) begin
                s1_e    <= n_e;
                s1_m    <= n_m;
                s1_g    <= n_g;
                s1_st   <= n_st;
                s1_sign <= in_sign;
                s1_zero <= ~|in_p;
                s1_rm   <= n_rm;
            end
            if (s2_load)        s2_v <= 1'b1;
            else if (out_ready) s2_v <= 1'b0;
            if (s2_load) begin
                out_result <= n_res;
                out_flags  <= n_flags;
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_norm_round_pipe.sv
// Bench for fp_mul_norm_round_pipe: directed vector table, backpressure and reset sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_fp_mul_norm_round_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_p;
    logic [9:0]  in_s;
    logic        in_sign;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    fp_mul_norm_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_p(in_p), .in_s(in_s), .in_sign(in_sign), .in_rm(in_rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] p;
        logic [9:0]  s;
        logic        sg;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [2:0]  fl;
    } vec_t;

    vec_t        vt[20];
    logic [34:0] expq[$];
    int          errors = 0;
    int          checks = 0;
    logic        prev_hold = 1'b0;
    logic [34:0] prev_out = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: integer significand with exact remainder, rounded by comparing against half an ulp.
    function automatic logic [34:0] model(input logic [47:0] p, input logic signed [9:0] s,
                                          input logic sg, input logic [2:0] rm);
        longint unsigned q, rem, half;
        int              drop, e;
        logic            up;
        logic [2:0]      mode;
        if (p == '0) return {sg, 31'd0, 3'b000};
        drop = p[47] ? 24 : 23;
        e    = int'(s) + (p[47] ? 1 : 0);
        q    = 64'(p) >> drop;
        rem  = 64'(p) - (q << drop);
        half = 64'd1 << (drop - 1);
        mode = (rm > 3'd4) ? 3'd0 : rm;
        case (mode)
            3'd0:    up = (rem > half) || (rem == half && q[0]);
            3'd1:    up = 1'b0;
            3'd2:    up = (rem != 0) && sg;
            3'd3:    up = (rem != 0) && !sg;
            default: up = (rem >= half);
        endcase
        q = q + 64'(up);
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) begin
            if (mode == 3'd0 || mode == 3'd4 || (mode == 3'd3 && !sg) || (mode == 3'd2 && sg))
                return {sg, 8'hFF, 23'd0, 3'b101};
            return {sg, 8'hFE, 23'h7FFFFF, 3'b101};
        end
        if (e <= 0) return {sg, 31'd0, 3'b011};
        return {sg, 8'(e), q[22:0], 2'b00, rem != 0};
    endfunction

    task automatic gen(output logic [47:0] p, output logic [9:0] s, output logic sg, output logic [2:0] rm);
        logic [63:0] r;
        int unsigned k;
        k = $urandom_range(0, 9);
        r = {$urandom(), $urandom()};
        p = r[47:0];
        if (k == 0) p = '0;
        else begin
            if (!p[47]) p[46] = 1'b1;
            if (k == 2) p[47:46] = 2'b01;
            if (k == 1) begin
                if (p[47]) p[23:0] = 24'h800000;
                else       p[22:0] = 23'h400000;
            end
        end
        s  = 10'($urandom_range(0, 420)) - 10'd140;
        sg = 1'($urandom_range(0, 1));
        rm = 3'($urandom_range(0, 7));
    endtask

    task automatic step(input logic v, input logic [47:0] p, input logic [9:0] s, input logic sg,
                        input logic [2:0] rm, input logic ordy, input logic [34:0] expv, output logic acc);
        @(negedge clk);
        in_valid  = v;
        in_p      = p;
        in_s      = s;
        in_sign   = sg;
        in_rm     = rm;
        out_ready = ordy;
        #1;
        if (prev_hold) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'({out_result, out_flags}), 64'(prev_out));
        end
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0h/%0h expected no output", out_result, out_flags);
            end else begin
                chk("result_flags", 64'({out_result, out_flags}), 64'(expq.pop_front()));
            end
        end
        prev_hold = out_valid && !out_ready;
        prev_out  = {out_result, out_flags};
        if (acc) expq.push_back(expv);
    endtask

    task automatic idle(input logic ordy);
        logic a;
        step(1'b0, '0, '0, 1'b0, 3'd0, ordy, '0, a);
    endtask

    initial begin
        logic        acc, have;
        logic [47:0] rp;
        logic [9:0]  rs;
        logic        rsg;
        logic [2:0]  rrm;
        int          idx;
        logic [47:0] bp[4];
        logic [9:0]  bs[4];
        logic        bsg[4];
        logic [2:0]  brm[4];

        vt[0]  = '{48'h9000_0000_0000, 10'd127, 1'b0, 3'd0, 32'h4010_0000, 3'b000};
        vt[1]  = '{48'hFFFF_FFFF_FFFF, 10'd127, 1'b0, 3'd0, 32'h4080_0000, 3'b001};
        vt[2]  = '{48'hFFFF_FFFF_FFFF, 10'd127, 1'b0, 3'd1, 32'h407F_FFFF, 3'b001};
        vt[3]  = '{48'hFFFF_FFFF_FFFF, 10'd127, 1'b0, 3'd7, 32'h4080_0000, 3'b001};
        vt[4]  = '{48'hFFFF_FFFF_FFFF, 10'd127, 1'b1, 3'd2, 32'hC080_0000, 3'b001};
        vt[5]  = '{48'hFFFF_FFFF_FFFF, 10'd127, 1'b0, 3'd2, 32'h407F_FFFF, 3'b001};
        vt[6]  = '{48'h8000_0000_0000, 10'd254, 1'b0, 3'd0, 32'h7F80_0000, 3'b101};
        vt[7]  = '{48'h8000_0000_0000, 10'd254, 1'b0, 3'd1, 32'h7F7F_FFFF, 3'b101};
        vt[8]  = '{48'h8000_0000_0000, 10'd254, 1'b1, 3'd3, 32'hFF7F_FFFF, 3'b101};
        vt[9]  = '{48'h8000_0000_0000, 10'd254, 1'b1, 3'd2, 32'hFF80_0000, 3'b101};
        vt[10] = '{48'hFFFF_FFFF_FFFF, 10'd253, 1'b0, 3'd0, 32'h7F80_0000, 3'b101};
        vt[11] = '{48'hFFFF_FFFF_FFFF, 10'd253, 1'b0, 3'd1, 32'h7F7F_FFFF, 3'b001};
        vt[12] = '{48'h4000_0000_0000, 10'd0,   1'b1, 3'd0, 32'h8000_0000, 3'b011};
        vt[13] = '{48'h4000_0000_0000, 10'h3FB, 1'b1, 3'd0, 32'h8000_0000, 3'b011};
        vt[14] = '{48'h0000_0000_0000, 10'd300, 1'b1, 3'd0, 32'h8000_0000, 3'b000};
        vt[15] = '{48'h4000_0000_0000, 10'd127, 1'b0, 3'd0, 32'h3F80_0000, 3'b000};
        vt[16] = '{48'h4000_0000_0000, 10'd1,   1'b0, 3'd0, 32'h0080_0000, 3'b000};
        vt[17] = '{48'h8000_0080_0000, 10'd127, 1'b0, 3'd4, 32'h4000_0001, 3'b001};
        vt[18] = '{48'h8000_0080_0000, 10'd127, 1'b0, 3'd0, 32'h4000_0000, 3'b001};
        vt[19] = '{48'h8000_0180_0000, 10'd127, 1'b0, 3'd0, 32'h4000_0002, 3'b001};

        rst_n = 1'b0; in_valid = 1'b0; in_p = '0; in_s = '0; in_sign = 1'b0; in_rm = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_flags", 64'(out_flags), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Latency: valid visible after the edge following the accepting edge.
        step(1'b1, vt[0].p, vt[0].s, vt[0].sg, vt[0].rm, 1'b1, {vt[0].res, vt[0].fl}, acc);
        chk("lat_accept", 64'(acc), 64'd1);
        idle(1'b1);
        chk("lat_early", 64'(out_valid), 64'd0);
        idle(1'b1);
        chk("lat_due", 64'(out_valid), 64'd1);

        foreach (vt[i]) begin
            step(1'b1, vt[i].p, vt[i].s, vt[i].sg, vt[i].rm, 1'b1, {vt[i].res, vt[i].fl}, acc);
            chk("tbl_accept", 64'(acc), 64'd1);
        end
        repeat (4) idle(1'b1);
        chk("tbl_drained", 64'(expq.size()), 64'd0);

        // Backpressure: 4 beats offered with out_ready low, then drained.
        for (int i = 0; i < 4; i++) gen(bp[i], bs[i], bsg[i], brm[i]);
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, bp[idx], bs[idx], bsg[idx], brm[idx], 1'b0,
                 model(bp[idx], bs[idx], bsg[idx], brm[idx]), acc);
            if (acc) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        for (int c = 0; c < 20 && (idx < 4 || expq.size() != 0); c++) begin
            if (idx < 4) begin
                step(1'b1, bp[idx], bs[idx], bsg[idx], brm[idx], 1'b1,
                     model(bp[idx], bs[idx], bsg[idx], brm[idx]), acc);
                if (acc) idx++;
            end else idle(1'b1);
        end
        chk("bp_all_sent", 64'(idx), 64'd4);
        chk("bp_drained", 64'(expq.size()), 64'd0);

        // Reset with two beats in flight.
        for (int i = 0; i < 2; i++) begin
            gen(rp, rs, rsg, rrm);
            step(1'b1, rp, rs, rsg, rrm, 1'b0, model(rp, rs, rsg, rrm), acc);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        expq.delete();
        prev_hold = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            idle(1'b1);
            chk("postrst_idle", 64'(out_valid), 64'd0);
        end
        step(1'b1, vt[1].p, vt[1].s, vt[1].sg, vt[1].rm, 1'b1, {vt[1].res, vt[1].fl}, acc);
        repeat (3) idle(1'b1);
        chk("postrst_drained", 64'(expq.size()), 64'd0);

        // Randomized traffic with random stalls on both sides.
        have = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                gen(rp, rs, rsg, rrm);
                have = 1'b1;
            end
            step(have, rp, rs, rsg, rrm, 1'($urandom_range(0, 3) != 0), model(rp, rs, rsg, rrm), acc);
            if (acc) have = 1'b0;
        end
        for (int c = 0; c < 20 && expq.size() != 0; c++) idle(1'b1);
        chk("rand_drained", 64'(expq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
